pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 39 +++
 rtl/pwm_period_counter.sv | 43 ++++
 rtl/pwm_ramp_ctrl.sv | 119 +++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM ramp controller: FSM state
// encoding, counter width, default period and the duty helper functions.
package pwm_pkg;

    localparam int               CNT_W          = 32;
    localparam logic [CNT_W-1:0] DEFAULT_PERIOD = 32'd100;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    // Limit a requested high-time to a full period (constant high).
    function automatic logic [CNT_W-1:0] clamp_duty(
        input logic [CNT_W-1:0] duty,
        input logic [CNT_W-1:0] period
    );
        return (duty > period) ? period : duty;
    endfunction

    // Move cur one step toward tgt without overshooting. The gap is
    // formed at CNT_W+1 bits so neither direction can wrap.
    function automatic logic [CNT_W-1:0] step_toward(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] tgt,
        input logic [CNT_W:0]   step
    );
        logic [CNT_W:0] gap;
        if (tgt > cur) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            return (gap > step) ? cur + step[CNT_W-1:0] : tgt;
        end else if (tgt < cur) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            return (gap > step) ? cur - step[CNT_W-1:0] : tgt;
        end
        return cur;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Shared period counter: counts 0..PERIOD-1 while enabled, holds when
// disabled, and flags the last cycle of each period.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter logic [CNT_W-1:0] PERIOD = DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_end;

    assign at_end = (count_q == PERIOD - 32'd1);

    // Next count: advance and wrap while enabled, otherwise hold.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (enable) begin
            count_d = at_end ? '0 : count_q + 32'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tick  = enable && !rst && at_end;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel PWM generator sharing one period counter. Each channel
// holds a target duty and a current duty; the current duty moves toward
// the target only on the last cycle of a period, so waveform changes land
// on a period boundary.
// Build option: define PWM_RAMP_STEP_EN to ramp by STEP per period;
// without it the current duty jumps to the target at the next period end.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter logic [CNT_W-1:0] PERIOD = DEFAULT_PERIOD,
    parameter int               NCH    = 4,
    parameter logic [CNT_W-1:0] STEP   = 32'd1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                     cfg_duty,
    output logic [NCH-1:0]                       pwm_out,
    output logic                                 period_tick,
    output logic                                 busy
);

`ifdef PWM_RAMP_STEP_EN
    localparam logic [CNT_W:0] EFF_STEP = {1'b0, STEP};
`else
    // cur and tgt never exceed PERIOD, so any step of at least PERIOD
    // lands on the target in one go: a straight copy.
    localparam logic [CNT_W:0] EFF_STEP = (STEP > PERIOD) ? {1'b0, STEP} : {1'b0, PERIOD};
`endif

    logic [CNT_W-1:0] count;
    logic             tick;

    logic [CNT_W-1:0] cur_q [NCH];
    logic [CNT_W-1:0] cur_d [NCH];
    logic [CNT_W-1:0] tgt_q [NCH];
    logic [CNT_W-1:0] tgt_d [NCH];
    state_e           state_q;
    state_e           state_d;
    logic             any_diff;
    logic             accept;

    pwm_period_counter #(
        .PERIOD (PERIOD)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .count  (count),
        .tick   (tick)
    );

    // No target write can coincide with a duty step.
    assign cfg_ready = !rst && !tick;
    assign accept    = cfg_valid && cfg_ready && (int'(cfg_ch) < NCH);

    // Target update: clamp and store on an accepted write to a real channel.
    always_comb begin
        tgt_d = tgt_q;
        if (accept) begin
            tgt_d[cfg_ch] = clamp_duty(cfg_duty, PERIOD);
        end
    end

    // Current duty: step toward the target on the last cycle of a period.
    always_comb begin
        cur_d = cur_q;
        if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                cur_d[i] = step_toward(cur_q[i], tgt_q[i], EFF_STEP);
            end
        end
    end

    // Ramp status: RAMP while any channel has not reached its target.
    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_q[i] != tgt_q[i]) begin
                any_diff = 1'b1;
            end
        end
        state_d = state_q;
        if (enable) begin
            state_d = any_diff ? RAMP : IDLE;
        end
    end

    // Channel state and FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the duty arrays are reset explicitly; a restart must come up with all outputs low.
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
        end
    end

    // Compare stage drives the pins directly.
    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_out[i] = enable && !rst && (count < cur_q[i]);
        end
    end

    assign period_tick = tick;
    assign busy        = (state_q == RAMP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed ramp/clamp/handshake
// scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of period, targets and duties.
module tb_pwm_ramp_ctrl;

    localparam logic [31:0] P    = 32'd10;
    localparam int          NCH  = 3;
    localparam logic [31:0] STEP = 32'd1;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [31:0]    cfg_duty;
    logic [NCH-1:0] pwm_out;
    logic           period_tick;
    logic           busy;

    pwm_ramp_ctrl #(
        .PERIOD (P),
        .NCH    (NCH),
        .STEP   (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_duty    (cfg_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    longint         m_cnt;
    longint         m_cur [NCH];
    longint         m_tgt [NCH];
    bit             m_busy;

    int             n_checks;
    int             n_pass;
    logic [NCH-1:0] obs_pwm;
    logic           obs_tick;
    int             g_highs [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic longint ramp(input longint c, input longint t);
`ifdef PWM_RAMP_STEP_EN
        if (t > c) return (c + STEP < t) ? c + STEP : t;
        if (t < c) return (c - STEP > t) ? c - STEP : t;
        return c;
`else
        return t;
`endif
    endfunction

    // One clock: drive inputs, compare outputs, advance the model.
    task automatic cycle(input bit r, input bit e, input bit v, input int ch, input logic [31:0] d);
        bit             tk;
        bit             rdy;
        bit             diff;
        logic [NCH-1:0] pw;
        longint         dd;
        @(negedge clk);
        rst       = r;
        enable    = e;
        cfg_valid = v;
        cfg_ch    = ch[1:0];
        cfg_duty  = d;
        #1;
        tk  = e && !r && (m_cnt == P - 1);
        rdy = !r && !tk;
        for (int i = 0; i < NCH; i++) pw[i] = !r && e && (m_cnt < m_cur[i]);
        check("period_tick", {31'b0, period_tick}, {31'b0, tk});
        check("cfg_ready", {31'b0, cfg_ready}, {31'b0, rdy});
        check("busy", {31'b0, busy}, {31'b0, m_busy});
        check("pwm_out", {29'b0, pwm_out}, {29'b0, pw});
        obs_pwm  = pwm_out;
        obs_tick = period_tick;
        if (r) begin
            m_cnt  = 0;
            m_busy = 0;
            for (int i = 0; i < NCH; i++) begin
                m_cur[i] = 0;
                m_tgt[i] = 0;
            end
        end else begin
            diff = 0;
            for (int i = 0; i < NCH; i++) if (m_cur[i] != m_tgt[i]) diff = 1;
            if (tk) for (int i = 0; i < NCH; i++) m_cur[i] = ramp(m_cur[i], m_tgt[i]);
            dd = d;
            if (v && rdy && ch < NCH) m_tgt[ch] = (dd > P) ? P : dd;
            if (e) begin
                m_busy = diff;
                m_cnt  = (m_cnt + 1) % P;
            end
        end
    endtask

    // Run enabled until the end of the current period, tallying high cycles.
    task automatic count_period();
        for (int i = 0; i < NCH; i++) g_highs[i] = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(0, 1, 0, 0, 0);
            for (int i = 0; i < NCH; i++) if (obs_pwm[i]) g_highs[i]++;
            if (obs_tick) break;
        end
        check("tick_seen", {31'b0, obs_tick}, 32'd1);
    endtask

    int exp_ramp [6];
    int en_hold;

    initial begin
        bit          r;
        bit          e;
        bit          v;
        int          ch;
        int          sel;
        logic [31:0] d;
`ifdef PWM_RAMP_STEP_EN
        exp_ramp = '{0, 1, 2, 3, 4, 4};
`else
        exp_ramp = '{0, 4, 4, 4, 4, 4};
`endif
        n_checks  = 0;
        n_pass    = 0;
        en_hold   = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_duty  = '0;
        m_cnt     = 0;
        m_busy    = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cur[i] = 0;
            m_tgt[i] = 0;
        end

        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);

        // Ramp ch0 from 0 to 4, observing the high time of each period.
        cycle(0, 1, 1, 0, 32'd4);
        for (int p = 0; p < 6; p++) begin
            count_period();
            check("ramp_ch0_highs", g_highs[0], exp_ramp[p]);
        end

        // Over-range duty clamps to a full period; zero gives constant low.
        cycle(0, 1, 1, 1, 32'd25);
        cycle(0, 1, 1, 0, 32'd0);
        for (int p = 0; p < 13; p++) count_period();
        check("clamp_ch1_highs", g_highs[1], P);
        check("zero_ch0_highs", g_highs[0], 32'd0);

        // Hold cfg_valid across the last cycle of a period.
        while (m_cnt != P - 2) cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 1, 2, 32'd6);

        // Single-cycle reset in the middle of a ramp.
        cycle(0, 1, 1, 0, 32'd9);
        for (int p = 0; p < 4; p++) count_period();
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("post_rst_pwm", {29'b0, pwm_out}, 32'd0);
        cycle(0, 1, 0, 0, 0);

        // Disable for seven cycles mid-period, writing a target meanwhile.
        cycle(0, 1, 1, 1, 32'd7);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) cycle(0, 0, (k == 2), 2, 32'd3);
        for (int p = 0; p < 10; p++) count_period();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            if (en_hold > 0) en_hold--;
            else if ($urandom_range(0, 39) == 0) en_hold = $urandom_range(1, 9);
            e   = (en_hold == 0);
            v   = ($urandom_range(0, 24) == 0) || ($urandom_range(0, 99) == 0 && !e);
            ch  = $urandom_range(0, 3);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       d = 32'd0;
                1:       d = P;
                2:       d = 32'hFFFF_FFFF;
                3:       d = P + $urandom_range(1, 50);
                default: d = $urandom_range(0, P - 1);
            endcase
            cycle(r, e, v, ch, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
